// File: rtl/y86_pkg.sv
// Y86-64 instruction codes, field bundle and length decode shared by fetch and the loader.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam int INSTR_LEN_MAX = 10;

  // Decoded instruction held by the encoder while its bytes stream out.
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [3:0]  len;
    logic        has_regs;
    logic        has_valc;
  } instr_t;

  // Returns {valid, len}; len is 0 for codes C..F.
  function automatic logic [4:0] instr_len(input logic [3:0] icode);
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                  instr_len = {1'b1, 4'd1};
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:  instr_len = {1'b1, 4'd2};
      ICODE_JXX, ICODE_CALL:                             instr_len = {1'b1, 4'd9};
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:          instr_len = {1'b1, 4'd10};
      default:                                           instr_len = {1'b0, 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode classifier: validity, byte length and which optional fields exist.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       valid,
  output logic [3:0] len,
  output logic       has_regs,
  output logic       has_valc
);

  // Register byte is present for the 2- and 10-byte forms, valC for the 9- and 10-byte forms.
  always_comb begin
    {valid, len} = instr_len(icode);
    has_regs     = (len == 4'd2) || (len == 4'd10);
    has_valc     = (len == 4'd9) || (len == 4'd10);
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction per handshake into byte writes at wr_ptr.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_ptr,
  input  logic [ADDR_W-1:0] ptr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] wr_ptr
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state, state_n;
  logic [3:0]        idx, idx_n;
  instr_t            fld, fld_n, in_fld;
  logic [ADDR_W-1:0] wp_n, addr_n;
  logic [7:0]        wdata_n;
  logic              we_n, done_n, err_n;

  logic              in_vld_code;
  logic [3:0]        in_len;
  logic              in_has_regs, in_has_valc;
  logic [ADDR_W:0]   end_addr;
  logic              ovf;

  y86_instr_len u_len (
    .icode    (icode),
    .valid    (in_vld_code),
    .len      (in_len),
    .has_regs (in_has_regs),
    .has_valc (in_has_valc)
  );

  // Byte k of an instruction: opcode byte, optional register byte, then valC little-endian.
  function automatic logic [7:0] byte_sel(input instr_t f, input logic [3:0] k);
    logic [3:0] vi;
    vi = k - 4'd1 - {3'b000, f.has_regs};
    if (k == 4'd0)                   byte_sel = {f.icode, f.ifun};
    else if (f.has_regs && k == 4'd1) byte_sel = {f.ra, f.rb};
    else if (f.has_valc)             byte_sel = f.valc[{vi[2:0], 3'b000} +: 8];
    else                             byte_sel = 8'h00;
  endfunction

  // Incoming fields bundled; overflow test is one bit wider so a pointer near the top cannot wrap.
  always_comb begin
    in_fld   = '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC,
                 len: in_len, has_regs: in_has_regs, has_valc: in_has_valc};
    end_addr = {1'b0, wr_ptr} + (ADDR_W+1)'(in_len);
    ovf      = end_addr > (ADDR_W+1)'(MEM_DEPTH);
    in_ready = (state == IDLE) && !set_ptr;
  end

  // Next-state and next registered outputs; byte 0 is issued directly from the accept edge.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    fld_n   = fld;
    wp_n    = wr_ptr;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (set_ptr) begin
          wp_n = ptr_in;
        end else if (in_valid) begin
          if (!in_vld_code || ovf) begin
            err_n = 1'b1;
          end else begin
            fld_n   = in_fld;
            state_n = EMIT;
            idx_n   = 4'd0;
            we_n    = 1'b1;
            addr_n  = wr_ptr;
            wdata_n = byte_sel(in_fld, 4'd0);
            done_n  = (in_len == 4'd1);
          end
        end
      end
      EMIT: begin
        if (idx == fld.len - 4'd1) begin
          state_n = IDLE;
          wp_n    = wr_ptr + ADDR_W'(fld.len);
        end else begin
          idx_n   = idx + 4'd1;
          we_n    = 1'b1;
          addr_n  = wr_ptr + ADDR_W'(idx + 4'd1);
          wdata_n = byte_sel(fld, idx + 4'd1);
          done_n  = (idx + 4'd1 == fld.len - 4'd1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, field latch, pointer and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      fld       <= '0;
      wr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      fld       <= fld_n;
      wr_ptr    <= wp_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Directed bench for the Y86-64 instruction encoder.
module tb_y86_instr_encoder;

  localparam int ADDR_W = 64;
  localparam int MEM_DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              set_ptr = 1'b0;
  logic [ADDR_W-1:0] ptr_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0]       valC = '0;
  logic              mem_we, done, err;
  logic [ADDR_W-1:0] mem_addr, wr_ptr;
  logic [7:0]        mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] tmem [0:MEM_DEPTH-1];
  int wcount = 0, dcount = 0, ecount = 0, done_wpos = 0;

  localparam logic [7:0] IRM [10] = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB,
                                      8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

  y86_instr_encoder #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .set_ptr(set_ptr), .ptr_in(ptr_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  // Memory model and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      tmem[mem_addr[9:0]] = mem_wdata;
      wcount = wcount + 1;
    end
    if (done) begin
      dcount = dcount + 1;
      done_wpos = wcount;
    end
    if (err) ecount = ecount + 1;
  end

  task automatic load_ptr(input logic [ADDR_W-1:0] p);
    @(negedge clk);
    set_ptr = 1'b1;
    ptr_in  = p;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL set_ptr_blocks_ready got=%b want=0", in_ready);
    end
    @(negedge clk);
    set_ptr = 1'b0;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++; checks++; $display("FAIL send_ready_timeout got=0 want=1");
    end
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL %s done_timeout got=0 want=1", nm);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, done, err} !== 4'b1000 || mem_addr !== '0 ||
        mem_wdata !== 8'h00 || wr_ptr !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b we=%b done=%b err=%b addr=%0h wd=%h ptr=%0h want 1 0 0 0 0 00 0",
               in_ready, mem_we, done, err, mem_addr, mem_wdata, wr_ptr);
    end
  endtask

  task automatic test_irmovq;
    int w0, d0;
    w0 = wcount; d0 = dcount;
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    wait_done("irmovq");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tmem[i] !== IRM[i]) begin
        errors++; $display("FAIL irmovq_byte%0d got=%h want=%h", i, tmem[i], IRM[i]);
      end
    end
    checks++;
    if (wcount - w0 != 10 || dcount - d0 != 1 || done_wpos - w0 != 10) begin
      errors++;
      $display("FAIL irmovq_counts got writes=%0d dones=%0d donepos=%0d want 10 1 10",
               wcount - w0, dcount - d0, done_wpos - w0);
    end
    checks++;
    if (wr_ptr !== 64'd10) begin
      errors++; $display("FAIL irmovq_wr_ptr got=%0d want=10", wr_ptr);
    end
  endtask

  task automatic test_short;
    int w0, d0;
    load_ptr(64'd50);
    checks++;
    if (wr_ptr !== 64'd50) begin
      errors++; $display("FAIL set_ptr_load got=%0d want=50", wr_ptr);
    end
    w0 = wcount; d0 = dcount;
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0); wait_done("halt");
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0); wait_done("nop");
    send(4'h9, 4'h0, 4'h0, 4'h0, 64'h0); wait_done("ret");
    checks++;
    if (tmem[50] !== 8'h00 || tmem[51] !== 8'h10 || tmem[52] !== 8'h90) begin
      errors++; $display("FAIL short_bytes got=%h %h %h want=00 10 90", tmem[50], tmem[51], tmem[52]);
    end
    checks++;
    if (wcount - w0 != 3 || dcount - d0 != 3 || wr_ptr !== 64'd53) begin
      errors++;
      $display("FAIL short_counts got writes=%0d dones=%0d ptr=%0d want 3 3 53",
               wcount - w0, dcount - d0, wr_ptr);
    end
  endtask

  task automatic test_jxx;
    int w0;
    load_ptr(64'd20);
    w0 = wcount;
    send(4'h7, 4'h3, 4'h5, 4'h6, 64'h40);
    wait_done("jxx");
    checks++;
    if (tmem[20] !== 8'h73 || tmem[21] !== 8'h40) begin
      errors++; $display("FAIL jxx_head got=%h %h want=73 40", tmem[20], tmem[21]);
    end
    for (int a = 22; a <= 28; a++) begin
      checks++;
      if (tmem[a] !== 8'h00) begin
        errors++; $display("FAIL jxx_byte@%0d got=%h want=00", a, tmem[a]);
      end
    end
    checks++;
    if (wcount - w0 != 9 || wr_ptr !== 64'd29) begin
      errors++; $display("FAIL jxx_counts got writes=%0d ptr=%0d want 9 29", wcount - w0, wr_ptr);
    end
  endtask

  task automatic test_err;
    int w0, e0;
    w0 = wcount; e0 = ecount;
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    repeat (4) @(negedge clk);
    checks++;
    if (ecount - e0 != 1 || wcount != w0 || wr_ptr !== 64'd29) begin
      errors++;
      $display("FAIL bad_icode got errs=%0d writes=%0d ptr=%0d want 1 0 29", ecount - e0, wcount - w0, wr_ptr);
    end
    load_ptr(64'(MEM_DEPTH - 5));
    w0 = wcount; e0 = ecount;
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h8);
    repeat (4) @(negedge clk);
    checks++;
    if (ecount - e0 != 1 || wcount != w0 || wr_ptr !== 64'(MEM_DEPTH - 5)) begin
      errors++;
      $display("FAIL overflow got errs=%0d writes=%0d ptr=%0d want 1 0 %0d",
               ecount - e0, wcount - w0, wr_ptr, MEM_DEPTH - 5);
    end
    // Exactly fills the last ten bytes: accepted.
    load_ptr(64'(MEM_DEPTH - 10));
    w0 = wcount; e0 = ecount;
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h8);
    wait_done("exact_fit");
    checks++;
    if (ecount != e0 || wcount - w0 != 10 || wr_ptr !== 64'(MEM_DEPTH) ||
        tmem[MEM_DEPTH-10] !== 8'h40 || tmem[MEM_DEPTH-9] !== 8'h12 || tmem[MEM_DEPTH-8] !== 8'h08) begin
      errors++;
      $display("FAIL exact_fit got errs=%0d writes=%0d ptr=%0d b=%h %h %h want 0 10 %0d 40 12 08",
               ecount - e0, wcount - w0, wr_ptr, tmem[MEM_DEPTH-10], tmem[MEM_DEPTH-9],
               tmem[MEM_DEPTH-8], MEM_DEPTH);
    end
  endtask

  task automatic test_emit_ignore;
    int w0, d0;
    load_ptr(64'd100);
    w0 = wcount; d0 = dcount;
    @(negedge clk);
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h2; valC = 64'h0123456789ABCDEF;
    in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL emit_ready cycle%0d got=%b want=0", k, in_ready);
      end
      in_valid = 1'b1; set_ptr = 1'b1; ptr_in = 64'd500; icode = 4'h1;
    end
    @(negedge clk);
    in_valid = 1'b0; set_ptr = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tmem[100+i] !== IRM[i]) begin
        errors++; $display("FAIL emit_ignore_byte%0d got=%h want=%h", i, tmem[100+i], IRM[i]);
      end
    end
    checks++;
    if (wcount - w0 != 10 || dcount - d0 != 1 || wr_ptr !== 64'd110) begin
      errors++;
      $display("FAIL emit_ignore_counts got writes=%0d dones=%0d ptr=%0d want 10 1 110",
               wcount - w0, dcount - d0, wr_ptr);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    load_ptr(64'd200);
    w0 = wcount;
    @(negedge clk);
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h2; valC = 64'h0123456789ABCDEF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, done, err} !== 4'b1000 || mem_addr !== '0 ||
        mem_wdata !== 8'h00 || wr_ptr !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got rdy=%b we=%b done=%b err=%b addr=%0h wd=%h ptr=%0h want 1 0 0 0 0 00 0",
               in_ready, mem_we, done, err, mem_addr, mem_wdata, wr_ptr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (wcount - w0 != 3 || tmem[200] !== 8'h30 || tmem[201] !== 8'hF2 || tmem[202] !== 8'hEF ||
        wr_ptr !== '0) begin
      errors++;
      $display("FAIL reset_mid_abort got writes=%0d b=%h %h %h ptr=%0d want 3 30 f2 ef 0",
               wcount - w0, tmem[200], tmem[201], tmem[202], wr_ptr);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_reset;
    test_irmovq;
    test_short;
    test_jxx;
    test_err;
    test_emit_ignore;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
